// File: rtl/buzzer_seq.sv
// Note sequencer: fetches {tone, beat} words over a req/ack port, plays each note for
// its beat count and keeps one prefetched note so note-to-note changes are gapless.
//
// state   | meaning
// IDLE    | stopped, tone muted, waiting for play
// FETCH   | current note not yet available, request outstanding or about to issue
// PLAY    | note sounding, beat counter running, next note prefetched
// DRAIN   | play dropped with a request outstanding, waiting to discard its ack
module buzzer_seq #(
    parameter int ADDR_W = 10,
    parameter int TONE_W = 12,
    parameter int BEAT_W = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       play,
    input  logic                       pause,
    input  logic                       loop_en,
    input  logic [ADDR_W-1:0]          base_addr,
    input  logic                       tick,
    output logic                       mem_req,
    output logic [ADDR_W-1:0]          mem_addr,
    input  logic                       mem_ack,
    input  logic [TONE_W+BEAT_W-1:0]   mem_rdata,
    output logic [TONE_W-1:0]          tone_period,
    output logic                       tone_en,
    output logic                       busy,
    output logic                       done
);
    localparam int WORD_W = TONE_W + BEAT_W;

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_PLAY, S_DRAIN} state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   addr_q;
    logic                req_q;
    logic [WORD_W-1:0]   buf_q;
    logic                buf_vld_q;
    logic [TONE_W-1:0]   tone_q;
    logic [BEAT_W-1:0]   cnt_q;
    logic                tone_en_q;
    logic                busy_q;
    logic                done_q;

    logic                ack_hit;
    logic                note_end;
    logic [ADDR_W-1:0]   addr_inc;
    logic                ld_en_d;
    logic [WORD_W-1:0]   ld_word_d;
    logic [TONE_W-1:0]   ld_tone;
    logic [BEAT_W-1:0]   ld_beat;

    assign ack_hit  = req_q & mem_ack;
    assign note_end = tick & ~pause & (cnt_q == BEAT_W'(1));
    assign addr_inc = addr_q + ADDR_W'(1);
    assign ld_tone  = ld_word_d[WORD_W-1:BEAT_W];
    assign ld_beat  = ld_word_d[BEAT_W-1:0];

    // A new current note comes from the fetch ack, the prefetch buffer, or an ack
    // that lands on the very cycle the previous note ends.
    always_comb begin
        ld_en_d   = 1'b0;
        ld_word_d = mem_rdata;
        if (play) begin
            if (state_q == S_FETCH && ack_hit) begin
                ld_en_d = 1'b1;
            end else if (state_q == S_PLAY && note_end) begin
                if (buf_vld_q) begin
                    ld_en_d   = 1'b1;
                    ld_word_d = buf_q;
                end else if (ack_hit) begin
                    ld_en_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            req_q     <= 1'b0;
            buf_q     <= '0;
            buf_vld_q <= 1'b0;
            tone_q    <= '0;
            cnt_q     <= '0;
            tone_en_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    tone_en_q <= 1'b0;
                    buf_vld_q <= 1'b0;
                    if (play) begin
                        addr_q  <= base_addr;
                        req_q   <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= S_FETCH;
                    end
                end
                S_FETCH, S_PLAY: begin
                    if (!play) begin
                        tone_en_q <= 1'b0;
                        buf_vld_q <= 1'b0;
                        if (req_q && !mem_ack) begin
                            state_q <= S_DRAIN;
                        end else begin
                            req_q   <= 1'b0;
                            busy_q  <= 1'b0;
                            state_q <= S_IDLE;
                        end
                    end else if (state_q == S_FETCH) begin
                        if (ack_hit) begin
                            req_q  <= 1'b0;
                            addr_q <= addr_inc;
                        end else if (!req_q) begin
                            req_q <= 1'b1;
                        end
                    end else begin
                        tone_en_q <= (tone_q != '0) && !pause;
                        if (note_end) begin
                            if (buf_vld_q) begin
                                buf_vld_q <= 1'b0;
                            end else if (ack_hit) begin
                                req_q  <= 1'b0;
                                addr_q <= addr_inc;
                            end else begin
                                state_q <= S_FETCH;
                                if (!req_q) req_q <= 1'b1;
                            end
                        end else begin
                            if (tick && !pause) cnt_q <= cnt_q - BEAT_W'(1);
                            if (ack_hit) begin
                                buf_q     <= mem_rdata;
                                buf_vld_q <= 1'b1;
                                req_q     <= 1'b0;
                                addr_q    <= addr_inc;
                            end else if (!buf_vld_q && !req_q) begin
                                req_q <= 1'b1;
                            end
                        end
                    end
                    // Loading overrides the bookkeeping above (end marker, fresh count).
                    if (ld_en_d) begin
                        if (ld_word_d == '0) begin
                            if (loop_en) begin
                                addr_q  <= base_addr;
                                state_q <= S_FETCH;
                            end else begin
                                done_q    <= 1'b1;
                                req_q     <= 1'b0;
                                busy_q    <= 1'b0;
                                tone_en_q <= 1'b0;
                                buf_vld_q <= 1'b0;
                                state_q   <= S_IDLE;
                            end
                        end else begin
                            tone_q    <= ld_tone;
                            cnt_q     <= (ld_beat == '0) ? BEAT_W'(1) : ld_beat;
                            tone_en_q <= (ld_tone != '0) && !pause;
                            state_q   <= S_PLAY;
                        end
                    end
                end
                S_DRAIN: begin
                    if (mem_ack) begin
                        req_q   <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign mem_req     = req_q;
    assign mem_addr    = addr_q;
    assign tone_period = tone_q;
    assign tone_en     = tone_en_q;
    assign busy        = busy_q;
    assign done        = done_q;
endmodule
